// File: rtl/tboom_rename_pkg.sv
// Shared types and helpers for the TinyBOOM N-wide rename map table.
// Widths here must match the map table's REG_*_ADDR_WIDTH parameters.
package tboom_rename_pkg;

    localparam int MAX_LANES  = 4;
    localparam int ARCH_W     = 5;
    localparam int PHYS_W     = 6;
    localparam int ARCH_REGS  = 2 ** ARCH_W;
    localparam int CKPT_DEPTH = 8;
    localparam int CKPT_W     = $clog2(CKPT_DEPTH);

    typedef logic [ARCH_W-1:0] arch_reg_t;
    typedef logic [PHYS_W-1:0] phys_reg_t;
    typedef logic [CKPT_W-1:0] ckpt_tag_t;
    typedef phys_reg_t [ARCH_REGS-1:0] map_t;

    typedef logic [MAX_LANES-1:0] lane_mask_t;
    typedef arch_reg_t [MAX_LANES-1:0] lane_arch_t;
    typedef phys_reg_t [MAX_LANES-1:0] lane_phys_t;

    function automatic map_t reset_map();
        map_t m;
        for (int i = 0; i < ARCH_REGS; i++) begin
            m[i] = phys_reg_t'(i);
        end
        return m;
    endfunction

    // Later older lanes overwrite earlier ones, so the newest producer wins.
    function automatic phys_reg_t lane_bypass(
        input int         lane,
        input arch_reg_t  src,
        input lane_mask_t wq,
        input lane_arch_t rd,
        input lane_phys_t np,
        input phys_reg_t  dflt
    );
        phys_reg_t r;
        r = dflt;
        for (int j = 0; j < MAX_LANES; j++) begin
            if (j < lane && wq[j] && rd[j] == src) begin
                r = np[j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tboom_rmt_ckpt_alloc.sv
// Circular checkpoint slot allocator: head/tail/count bookkeeping.
module tboom_rmt_ckpt_alloc
    import tboom_rename_pkg::*;
#(
    parameter int DEPTH = CKPT_DEPTH,
    localparam int TW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc,
    input  logic          release_req,
    input  logic          restore,
    input  logic [TW-1:0] restore_tag,
    input  logic          clear,
    output logic [TW-1:0] tag,
    output logic          full
);

    logic [TW-1:0] head_q;
    logic [TW-1:0] tail_q;
    logic [TW:0]   count_q;
    logic [TW-1:0] span;
    logic          rel_ok;
    logic          live;

    assign rel_ok = release_req && (count_q != '0);
    assign span   = restore_tag - head_q;
    assign live   = {1'b0, span} < count_q;
    assign full   = (count_q == (TW+1)'(DEPTH));
    assign tag    = tail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            tail_q  <= head_q;
            count_q <= '0;
        end else if (restore) begin
            // Keep the restored slot and everything older; drop the rest.
            tail_q  <= restore_tag + TW'(1);
            count_q <= {1'b0, span} + (TW+1)'(1);
        end else begin
            if (alloc) begin
                tail_q <= tail_q + TW'(1);
            end
            if (rel_ok) begin
                head_q <= head_q + TW'(1);
            end
            count_q <= count_q + (TW+1)'(alloc) - (TW+1)'(rel_ok);
        end
    end

    a_restore_live: assert property (
        @(posedge clk) disable iff (!rst_n) (restore && !clear) |-> live
    );

endmodule

// File: rtl/tboom_rename_map_table_nw.sv
// N-wide rename map table with intra-group bypass and branch checkpoints.
// Define TBOOM_RMT_COMMIT_MAP_EN to add a committed map and flush recovery.
module tboom_rename_map_table_nw
    import tboom_rename_pkg::*;
#(
    parameter int RENAME_WIDTH        = 2,
    parameter int REG_ARCH_ADDR_WIDTH = ARCH_W,
    parameter int REG_PHYS_ADDR_WIDTH = PHYS_W,
    parameter int CHECKPOINT_DEPTH    = CKPT_DEPTH,
    localparam int RW = RENAME_WIDTH,
    localparam int AW = REG_ARCH_ADDR_WIDTH,
    localparam int PW = REG_PHYS_ADDR_WIDTH,
    localparam int TW = $clog2(CHECKPOINT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ren_valid,
    output logic             ren_ready,
    input  logic [RW-1:0]    lane_valid,
    input  logic [RW-1:0]    lane_rd_valid,
    input  logic [RW-1:0]    lane_rs1_valid,
    input  logic [RW-1:0]    lane_rs2_valid,
    input  logic [RW*AW-1:0] lane_arch_rs1,
    input  logic [RW*AW-1:0] lane_arch_rs2,
    input  logic [RW*AW-1:0] lane_arch_rd,
    input  logic [RW*PW-1:0] lane_new_phys,
    input  logic             freelist_ok,
    output logic [RW-1:0]    freelist_request,
    output logic [RW*PW-1:0] lane_phys_rs1,
    output logic [RW*PW-1:0] lane_phys_rs2,
    output logic [RW*PW-1:0] lane_phys_stale,
    input  logic             ckpt_req,
    output logic [TW-1:0]    ckpt_tag,
    input  logic             restore,
    input  logic [TW-1:0]    restore_tag,
    input  logic             ckpt_release,
`ifdef TBOOM_RMT_COMMIT_MAP_EN
    input  logic [RW-1:0]    commit_valid,
    input  logic [RW*AW-1:0] commit_arch_rd,
    input  logic [RW*PW-1:0] commit_phys_rd,
    input  logic             flush,
`endif
    output logic             ckpt_full
);

    map_t       map_q;
    map_t       map_nxt;
    map_t       recover_map;
    map_t       snap_q [CHECKPOINT_DEPTH];
    lane_mask_t wq;
    lane_arch_t rs1_a;
    lane_arch_t rs2_a;
    lane_arch_t rd_a;
    lane_phys_t np_a;
    logic       flush_i;
    logic       accept;

    always_comb begin
        wq    = '0;
        rs1_a = '0;
        rs2_a = '0;
        rd_a  = '0;
        np_a  = '0;
        for (int k = 0; k < RW; k++) begin
            rs1_a[k] = lane_arch_rs1[k*AW +: AW];
            rs2_a[k] = lane_arch_rs2[k*AW +: AW];
            rd_a[k]  = lane_arch_rd[k*AW +: AW];
            np_a[k]  = lane_new_phys[k*PW +: PW];
            wq[k]    = lane_valid[k] & lane_rd_valid[k] & (rd_a[k] != '0);
        end
    end

    assign freelist_request = wq[RW-1:0];

    always_comb begin
        lane_phys_rs1   = '0;
        lane_phys_rs2   = '0;
        lane_phys_stale = '0;
        for (int k = 0; k < RW; k++) begin
            if (lane_rs1_valid[k] && rs1_a[k] != '0) begin
                lane_phys_rs1[k*PW +: PW] =
                    lane_bypass(k, rs1_a[k], wq, rd_a, np_a, map_q[rs1_a[k]]);
            end
            if (lane_rs2_valid[k] && rs2_a[k] != '0) begin
                lane_phys_rs2[k*PW +: PW] =
                    lane_bypass(k, rs2_a[k], wq, rd_a, np_a, map_q[rs2_a[k]]);
            end
            lane_phys_stale[k*PW +: PW] =
                lane_bypass(k, rd_a[k], wq, rd_a, np_a, map_q[rd_a[k]]);
        end
    end

    // Lane order makes the highest lane win a same-rd conflict.
    always_comb begin
        map_nxt = map_q;
        for (int k = 0; k < RW; k++) begin
            if (wq[k]) begin
                map_nxt[rd_a[k]] = np_a[k];
            end
        end
    end

`ifdef TBOOM_RMT_COMMIT_MAP_EN
    map_t cmap_q;
    map_t cmap_nxt;

    always_comb begin
        cmap_nxt = cmap_q;
        for (int k = 0; k < RW; k++) begin
            if (commit_valid[k] && commit_arch_rd[k*AW +: AW] != '0) begin
                cmap_nxt[commit_arch_rd[k*AW +: AW]] = commit_phys_rd[k*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmap_q <= reset_map();
        end else begin
            cmap_q <= cmap_nxt;
        end
    end

    assign flush_i     = flush;
    assign recover_map = flush ? cmap_q : snap_q[restore_tag];
`else
    assign flush_i     = 1'b0;
    assign recover_map = snap_q[restore_tag];
`endif

    assign ren_ready = !flush_i && !restore && freelist_ok
                     && !(ckpt_req && ckpt_full);
    assign accept    = ren_valid && ren_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q <= reset_map();
        end else if (flush_i || restore) begin
            map_q <= recover_map;
        end else if (accept) begin
            map_q <= map_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && ckpt_req) begin
            snap_q[ckpt_tag] <= map_nxt;
        end
    end

    tboom_rmt_ckpt_alloc #(
        .DEPTH(CHECKPOINT_DEPTH)
    ) u_alloc (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc      (accept && ckpt_req),
        .release_req(ckpt_release),
        .restore    (restore),
        .restore_tag(restore_tag),
        .clear      (flush_i),
        .tag        (ckpt_tag),
        .full       (ckpt_full)
    );

endmodule

// File: doc/tboom_rename_map_table_nw.md
Name: tboom_rename_map_table_nw

Overview:
- N-wide rename map table (RMT) for the TinyBOOM rename stage; generalises the 2-lane RMT to RENAME_WIDTH lanes.
- Holds the arch->phys mapping and performs combinational lookup with intra-group dependency bypass.
- Owns a circular checkpoint allocator: branch snapshot, restore and in-order release.
- Sits between decode and dispatch; takes physical registers from the free list and emits stale tags for the ROB.

Parameters:
- RENAME_WIDTH, 2, lanes renamed per cycle (1..4)
- REG_ARCH_ADDR_WIDTH, 5, arch register index width; ARCH_REGS = 2**REG_ARCH_ADDR_WIDTH
- REG_PHYS_ADDR_WIDTH, 6, physical register tag width
- CHECKPOINT_DEPTH, 8, snapshot slots (power of two, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ren_valid  in  1  rename group offered
- ren_ready  out  1  group accepted this cycle when ren_valid && ren_ready
- lane_valid  in  RENAME_WIDTH  per-lane not-bubble
- lane_rd_valid / lane_rs1_valid / lane_rs2_valid  in  RENAME_WIDTH each  operand present
- lane_arch_rs1 / lane_arch_rs2 / lane_arch_rd  in  RENAME_WIDTH*REG_ARCH_ADDR_WIDTH each  arch indices
- lane_new_phys  in  RENAME_WIDTH*REG_PHYS_ADDR_WIDTH  free-list tag per lane
- freelist_ok  in  1  free list can supply every requested lane
- freelist_request  out  RENAME_WIDTH  lane_valid & lane_rd_valid & (rd!=0)
- lane_phys_rs1 / lane_phys_rs2 / lane_phys_stale  out  RENAME_WIDTH*REG_PHYS_ADDR_WIDTH each
- ckpt_req  in  1  snapshot the post-group mapping (group ends in a branch)
- ckpt_tag  out  $clog2(CHECKPOINT_DEPTH)  tag allocated on an accepted ckpt_req
- ckpt_full  out  1  no free slot
- restore  in  1  mispredict: restore snapshot restore_tag
- restore_tag  in  $clog2(CHECKPOINT_DEPTH)
- release  in  1  oldest checkpoint resolved correctly; free it

Behaviour:
- Reset (async): map[i]=i for all i; head=tail=0; count=0. ckpt_full=0, ckpt_tag=0. Outputs reflect the reset map combinationally.
- Lookup, 0-cycle: lane k rsX = newest older lane j<k with a write-qualifying rd==rsX, giving lane_new_phys[j]; otherwise map[rsX].
- Invalid rs, or arch x0: output 0.
- lane_phys_stale: same bypass applied to rd; value is don't-care when rd is invalid.
- Write qualifier per lane: lane_valid & lane_rd_valid & rd!=0. x0 is never written.
- Commit: table is updated at posedge only on an accepted group. Same-rd conflict: highest lane wins.
- ren_ready = !restore && freelist_ok && !(ckpt_req && ckpt_full).
- Checkpoint: on accepted group with ckpt_req, snap[tail] <= post-group map (includes this cycle's writes); ckpt_tag = tail (combinational); tail++, count++.
- Wrap-around: head and tail are modulo CHECKPOINT_DEPTH; count distinguishes full from empty.
- Restore takes priority over everything in the same cycle:
  - map <= snap[restore_tag];
  - tail <= restore_tag+1; count <= restore_tag-head+1 (mod depth), so younger checkpoints are discarded;
  - group writes suppressed; release ignored.
- Release: if count>0, head++, count--. Release with count==0 is ignored.
- Release together with checkpoint: count unchanged; head and tail both advance.
- Restore of a tag not live: undefined; flagged by assertion.
- Mid-operation rst_n assertion: immediate return to reset state; snapshots need not be cleared.

Optional Feature:
- Macro TBOOM_RMT_COMMIT_MAP_EN.
- Defined:
  - adds a committed map table and ports commit_valid (RENAME_WIDTH), commit_arch_rd and commit_phys_rd;
  - committed map updates in lane order;
  - adds input flush (1): map <= committed map; all checkpoints freed (head=tail, count=0); takes priority over restore.
- Undefined: none of these ports or storage exist; recovery is via checkpoints only.

Decomposition:
- Package tboom_rename_pkg:
  - typedefs arch_reg_t, phys_reg_t, ckpt_tag_t, map_t (array of phys_reg_t);
  - constants for reset mapping;
  - function lane_bypass() used by both lookup paths.
- Sub-module tboom_rmt_ckpt_alloc: head/tail/count allocator, ckpt_full and tag arithmetic.

Test Plan:
- Reset, no writes, rs1=5, rs2=0 valid -> phys_rs1=5, phys_rs2=0; rs1_valid=0 -> 0.
- Lane0 rd=3 new=40, lane1 rs1=3 -> lane1 phys_rs1=40 same cycle, lane1 stale of rd=3 = 40. After accept, map[3]=40. Both lanes rd=7 (41, 42) -> map[7]=42.
- Accept with ckpt_req, lane0 rd=4 new=50 -> ckpt_tag=0. Next group writes map[4]=51; restore tag 0 -> map[4]=50, ren_ready=0 in the restore cycle.
- Allocate 8 checkpoints -> ckpt_full=1, ren_ready=0 while ckpt_req; release -> ckpt_full=0, next tag=0 (wrap).
- Checkpoints 0,1,2 live, restore tag 1 -> count=2, next tag=2; simultaneous release ignored.
- With TBOOM_RMT_COMMIT_MAP_EN: commit rd=9->60, speculative map[9]=61, flush -> map[9]=60, ckpt count=0.
